apb_cmd_initiator: RTL and testbench

Byte-stream-to-APB initiator. It accepts command bytes on a valid/ready stream, runs one APB3 transfer per command against a 5-bit-address, 8-bit-data completer (such as the debugger register file), and returns one response byte per transfer on a second valid/ready stream. It is the requester counterpart to the team's APB completers and lets a host-facing front end (UART/SPI/test pins) reach any APB register block.

---
 rtl/apb_cmd_pkg.sv | 21 ++
 rtl/apb_wait_timer.sv | 36 +++
 rtl/apb_cmd_initiator.sv | 125 ++++++++++++
 tb/tb_apb_cmd_initiator.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_cmd_pkg.sv
// Shared types and constants for the byte-stream-to-APB initiator.
// The optional timeout path is enabled with the APB_TIMEOUT_EN macro.
package apb_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_DATA,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  // Command byte layout: bit7 = write, bits6:5 reserved, bits4:0 = address.
  localparam int CMD_WRITE_BIT = 7;
  localparam int CMD_ADDR_MSB  = 4;
  localparam int CMD_ADDR_LSB  = 0;

  localparam logic [7:0] RSP_WRITE_OK = 8'h00;
  localparam logic [7:0] RSP_ERR      = 8'hFF;

endpackage

// File: rtl/apb_wait_timer.sv
// Load/count/expire down-counter bounding APB ACCESS wait states.
// Only instantiated when APB_TIMEOUT_EN is defined.
module apb_wait_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_value;
    end else if (en && (count_reg != '0)) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/apb_cmd_initiator.sv
// Byte-stream command front end driving one APB3 transfer per command.
// Define APB_TIMEOUT_EN to abandon transfers whose PREADY never arrives.
module apb_cmd_initiator
  import apb_cmd_pkg::*;
#(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              PRESETn,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  state_t              state_reg;
  state_t              state_next;
  logic                pwrite_reg;
  logic [ADDR_W-1:0]   paddr_reg;
  logic [DATA_W-1:0]   pwdata_reg;
  logic [DATA_W-1:0]   rsp_data_reg;
  logic                timed_out;
  logic                unused_rsvd;

  assign unused_rsvd = ^cmd_data[6:5];

`ifdef APB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic tmr_expired;
  logic rsp_err_reg;

  // Loaded with TIMEOUT_CYCLES-1 so it reads zero during the last allowed ACCESS cycle.
  apb_wait_timer #(.WIDTH(TMR_W)) u_wait_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (state_reg == SETUP),
    .load_value (TMR_W'(TIMEOUT_CYCLES - 1)),
    .en         (state_reg == ACCESS),
    .expired    (tmr_expired)
  );

  assign timed_out = (state_reg == ACCESS) && !PREADY && tmr_expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err_reg <= 1'b0;
    end else if (state_reg == ACCESS) begin
      if (PREADY) begin
        rsp_err_reg <= 1'b0;
      end else if (timed_out) begin
        rsp_err_reg <= 1'b1;
      end
    end
  end

  assign rsp_err = rsp_err_reg;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timed_out = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (cmd_valid) state_next = cmd_data[CMD_WRITE_BIT] ? GET_DATA : SETUP;
      GET_DATA: if (cmd_valid) state_next = SETUP;
      SETUP:    state_next = ACCESS;
      ACCESS:   if (PREADY || timed_out) state_next = RESP;
      RESP:     if (rsp_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pwrite_reg   <= 1'b0;
      paddr_reg    <= '0;
      pwdata_reg   <= '0;
      rsp_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && cmd_valid) begin
        pwrite_reg <= cmd_data[CMD_WRITE_BIT];
        paddr_reg  <= ADDR_W'(cmd_data[CMD_ADDR_MSB:CMD_ADDR_LSB]);
      end
      if ((state_reg == GET_DATA) && cmd_valid) begin
        pwdata_reg <= cmd_data;
      end
      // PRDATA is only trusted in the ACCESS cycle that completes the transfer.
      if (state_reg == ACCESS) begin
        if (PREADY) begin
          rsp_data_reg <= pwrite_reg ? DATA_W'(RSP_WRITE_OK) : PRDATA;
        end else if (timed_out) begin
          rsp_data_reg <= DATA_W'(RSP_ERR);
        end
      end
    end
  end

  assign cmd_ready = (state_reg == IDLE) || (state_reg == GET_DATA);
  assign rsp_valid = (state_reg == RESP);
  assign PSEL      = (state_reg == SETUP) || (state_reg == ACCESS);
  assign PENABLE   = (state_reg == ACCESS);
  assign PWRITE    = pwrite_reg;
  assign PADDR     = paddr_reg;
  assign PWDATA    = pwdata_reg;
  assign rsp_data  = rsp_data_reg;
  assign PRESETn   = ~rst;

endmodule

// File: tb/tb_apb_cmd_initiator.sv
// Directed plus randomized bench for apb_cmd_initiator against a 32-byte APB completer.
// Build with APB_TIMEOUT_EN defined to exercise the timeout path (TIMEOUT_CYCLES=4).
`timescale 1ns/1ps
module tb_apb_cmd_initiator;

  localparam int TMO = 4;
`ifdef APB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       PRESETn, PSEL, PENABLE, PWRITE, PREADY;
  logic [4:0] PADDR;
  logic [7:0] PWDATA, PRDATA;

  int vectors = 0;
  int miscompares = 0;
  int xfer_no = 0;

  logic [7:0] slv_mem [32];
  logic [7:0] ref_mem [32];
  int wait_cfg = 0;
  int wait_left = 0;

  always #5 clk = ~clk;

  apb_cmd_initiator #(.ADDR_W(5), .DATA_W(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  // Completer: wait_cfg wait states per transfer, garbage on PRDATA until ready.
  assign PREADY = (wait_left == 0);
  assign PRDATA = PREADY ? slv_mem[PADDR] : ~slv_mem[PADDR];

  always @(posedge clk) begin
    if (PSEL && !PENABLE) wait_left <= wait_cfg;
    else if (PSEL && PENABLE && wait_left > 0) wait_left <= wait_left - 1;
    if (PSEL && PENABLE && PREADY && PWRITE) slv_mem[PADDR] <= PWDATA;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full command: expectations come from ref_mem and the transfer rules only.
  task automatic run_xfer(input bit wr, input logic [1:0] rsv, input logic [4:0] addr,
                          input logic [7:0] data, input int waits, input int gap, input int bp);
    bit         tmo;
    int         n_acc;
    logic [7:0] exp_data;
    tmo      = TMO_ON && (waits >= TMO);
    n_acc    = tmo ? TMO : waits + 1;
    exp_data = tmo ? 8'hFF : (wr ? 8'h00 : ref_mem[addr]);
    if (wr && !tmo) ref_mem[addr] = data;
    wait_cfg = waits;

    check("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_data  = {wr, rsv, addr};
    tick();
    if (wr) begin
      cmd_valid = 1'b0;
      for (int i = 0; i < gap; i++) begin
        check("get_data_psel", PSEL, 0);
        tick();
      end
      check("get_data_ready", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_data  = data;
      tick();
    end
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_data  = 8'($urandom);

    check("setup_psel_pen", {PSEL, PENABLE}, 2'b10);
    check("setup_paddr", PADDR, addr);
    check("setup_pwrite", PWRITE, wr);
    check("setup_cmd_ready", cmd_ready, 0);
    if (wr) check("setup_pwdata", PWDATA, data);
    tick();
    for (int i = 0; i < n_acc; i++) begin
      check("access_psel_pen", {PSEL, PENABLE}, 2'b11);
      check("access_paddr", PADDR, addr);
      check("access_pwrite", PWRITE, wr);
      if (wr) check("access_pwdata", PWDATA, data);
      check("access_rsp_valid", rsp_valid, 0);
      tick();
    end
    check("resp_valid", rsp_valid, 1);
    check("resp_psel_pen", {PSEL, PENABLE}, 2'b00);
    check("resp_data", rsp_data, exp_data);
    check("resp_err", rsp_err, tmo);
    for (int i = 0; i < bp; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = 8'($urandom);
      tick();
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_data", rsp_data, exp_data);
      check("bp_cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_cmd_ready", cmd_ready, 1);
    check("post_psel", PSEL, 0);
    xfer_no++;
    $display("xfer %0d %s addr=%02h wdata=%02h waits=%0d bp=%0d rsp=%02h err=%0d",
             xfer_no, wr ? "WR" : "RD", addr, data, waits, bp, rsp_data, rsp_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      slv_mem[i] = 8'($urandom);
      ref_mem[i] = slv_mem[i];
    end
    slv_mem[5] = 8'h3C;
    ref_mem[5] = 8'h3C;

    // Reset values
    rst = 1'b1;
    repeat (3) tick();
    check("rst_presetn", PRESETn, 0);
    check("rst_outputs", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, PADDR, PWDATA, rsp_data}, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    rst = 1'b0;
    tick();
    check("run_presetn", PRESETn, 1);
    check("run_cmd_ready", cmd_ready, 1);

    // Zero-wait read, write, reserved bits, read-back
    run_xfer(1'b0, 2'b00, 5'h05, 8'h00, 0, 0, 0);
    run_xfer(1'b1, 2'b00, 5'h12, 8'hA5, 0, 0, 0);
    run_xfer(1'b0, 2'b00, 5'h12, 8'h00, 0, 0, 0);
    run_xfer(1'b1, 2'b11, 5'h12, 8'h5B, 0, 0, 0);
    run_xfer(1'b0, 2'b11, 5'h12, 8'h00, 0, 0, 0);

    // Wait states, slow second byte, backpressure
    run_xfer(1'b0, 2'b00, 5'h05, 8'h00, 3, 0, 0);
    run_xfer(1'b1, 2'b01, 5'h1F, 8'hC3, 3, 2, 0);
    run_xfer(1'b0, 2'b10, 5'h1F, 8'h00, 0, 0, 5);

    // Stuck completer (times out only when enabled) and ready in the last allowed cycle
    run_xfer(1'b0, 2'b00, 5'h03, 8'h00, 6, 0, 0);
    run_xfer(1'b1, 2'b00, 5'h04, 8'h77, 6, 0, 1);
    run_xfer(1'b0, 2'b00, 5'h03, 8'h00, TMO - 1, 0, 0);
    run_xfer(1'b0, 2'b00, 5'h04, 8'h00, 0, 0, 0);

    // Reset in the middle of ACCESS discards the transfer
    wait_cfg  = 5;
    cmd_valid = 1'b1;
    cmd_data  = 8'h07;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("mid_access_penable", {PSEL, PENABLE}, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_psel_pen", {PSEL, PENABLE}, 2'b00);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_no_rsp", {rsp_valid, PSEL}, 2'b00);
    end
    rsp_ready = 1'b0;
    run_xfer(1'b0, 2'b00, 5'h07, 8'h00, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      bit         r_wr;
      logic [1:0] r_rsv;
      logic [4:0] r_addr;
      logic [7:0] r_data;
      int         r_waits;
      r_wr    = 1'($urandom_range(0, 1));
      r_rsv   = 2'($urandom_range(0, 3));
      r_addr  = 5'($urandom_range(0, 31));
      r_data  = 8'($urandom);
      r_waits = ($urandom_range(0, 7) == 0) ? 6 : int'($urandom_range(0, 3));
      run_xfer(r_wr, r_rsv, r_addr, r_data, r_waits,
               int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
